// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter and instruction fetch sequencer
//
// Owns the 8-bit fetch PC. It fetches words from instruction memory over a
// req/ack handshake and presents them to decode over a valid/ready handshake.
// A taken branch from execute redirects the PC, pulses flush for one cycle and
// discards any fetch that is still in flight.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   start, halt_req              leave IDLE / stop fetching at next decision
//   imem_req/addr/ack/rdata      instruction memory handshake
//   instr_valid/ready, instr,
//   instr_pc                     word presented to decode
//   branch_valid/mode/reg/imm/pc redirect request from execute
//   pc, link_addr                fetch PC and captured return address
//   flush, halted, fetch_error   redirect pulse, halt state, sticky ack timeout
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [7:0]  instr_pc,
  input  logic        branch_valid,
  input  logic        branch_mode,
  input  logic [31:0] branch_reg,
  input  logic [31:0] branch_imm,
  input  logic [7:0]  branch_pc,
  output logic [7:0]  pc,
  output logic [7:0]  link_addr,
  output logic        flush,
  output logic        halted,
  output logic        fetch_error
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state, state_n;
  logic [7:0]  wait_cnt, cnt_n;
  logic        drop, drop_n;
  logic        halt_pend, hpend_n;
  logic [7:0]  pc_n, addr_n, ipc_n, link_n;
  logic [31:0] instr_n;
  logic        req_n, valid_n, flush_n, err_n;
  logic        redirect, halt_now;
  logic [7:0]  target;
  logic        unused_hi;

  // Only the low byte of the PC-relative sum matters, and it depends only on
  // the low bytes of the operands, so the upper bits are intentionally dropped.
  assign target    = branch_mode ? branch_reg[7:0] : branch_pc + branch_imm[7:0];
  assign unused_hi = ^{branch_reg[31:8], branch_imm[31:8]};
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 8'h0;
      link_addr   <= 8'h0;
      flush       <= 1'b0;
      fetch_error <= 1'b0;
      wait_cnt    <= 8'h0;
      drop        <= 1'b0;
      halt_pend   <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      imem_req    <= req_n;
      imem_addr   <= addr_n;
      instr_valid <= valid_n;
      instr       <= instr_n;
      instr_pc    <= ipc_n;
      link_addr   <= link_n;
      flush       <= flush_n;
      fetch_error <= err_n;
      wait_cnt    <= cnt_n;
      drop        <= drop_n;
      halt_pend   <= hpend_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    req_n    = imem_req;
    addr_n   = imem_addr;
    valid_n  = instr_valid;
    instr_n  = instr;
    ipc_n    = instr_pc;
    link_n   = link_addr;
    flush_n  = 1'b0;
    err_n    = fetch_error;
    cnt_n    = wait_cnt;
    drop_n   = drop;
    hpend_n  = halt_pend;
    redirect = 1'b0;

    // A halt request seen while fetching is remembered so it can be honoured
    // at the next decision point (after an ack, or after a redirect).
    if (state == S_REQ || state == S_WAIT || state == S_HOLD) begin
      redirect = branch_valid;
      if (halt_req) hpend_n = 1'b1;
    end
    halt_now = halt_req | halt_pend;

    if (redirect) begin
      pc_n    = target;
      link_n  = branch_pc + 8'd1;
      flush_n = 1'b1;
      valid_n = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (halt_req)   state_n = S_HALT;
        else if (start) state_n = S_REQ;
      end
      S_REQ: begin
        // A redirect here stays in REQ so the request goes out at the target.
        if (!redirect) begin
          if (halt_now) begin
            state_n = S_HALT;
          end else begin
            req_n   = 1'b1;
            addr_n  = pc;
            cnt_n   = 8'h0;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_n  = 1'b0;
          drop_n = 1'b0;
          if (redirect || drop) begin
            state_n = S_REQ;
          end else begin
            instr_n = imem_rdata;
            ipc_n   = imem_addr;
            valid_n = 1'b1;
            pc_n    = pc + 8'd1;
            state_n = S_HOLD;
          end
        end else if (wait_cnt == LAST_WAIT) begin
          err_n   = 1'b1;
          req_n   = 1'b0;
          drop_n  = 1'b0;
          state_n = S_HALT;
        end else begin
          cnt_n = wait_cnt + 8'd1;
          if (redirect) drop_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_n = S_REQ;
        end else if (instr_ready) begin
          valid_n = 1'b0;
          state_n = halt_now ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        req_n = 1'b0;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
//
// Drives directed scenarios and a randomized fetch/branch/backpressure run.
// A memory responder returns addr+0x100 after a programmable latency; the
// expected decode stream and branch targets come from a small reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        branch_valid = 1'b0;
  logic        branch_mode = 1'b0;
  logic [31:0] branch_reg = 32'h0;
  logic [31:0] branch_imm = 32'h0;
  logic [7:0]  branch_pc = 8'h0;
  logic [7:0]  pc;
  logic [7:0]  link_addr;
  logic        flush;
  logic        halted;
  logic        fetch_error;

  int   errors = 0;
  int   checks = 0;
  int   mem_lat = 2;
  bit   mem_en = 1'b1;
  int   mcnt = 0;
  int   found, spur, reqs;

  logic [7:0]  exp_pc, bpc, tgt;
  logic [31:0] r, imm;
  logic        mode;

  fetch_sequencer #(.RESET_PC(8'h00), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .branch_valid(branch_valid), .branch_mode(branch_mode),
    .branch_reg(branch_reg), .branch_imm(branch_imm), .branch_pc(branch_pc),
    .pc(pc), .link_addr(link_addr), .flush(flush), .halted(halted),
    .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'h100 + {24'h0, a};
  endfunction

  function automatic logic [7:0] model_target(input logic m, input logic [31:0] rv,
                                              input logic [31:0] iv, input logic [7:0] bp);
    logic [31:0] s;
    s = {24'h0, bp} + iv;
    return m ? rv[7:0] : s[7:0];
  endfunction

  // Instruction memory: one-cycle ack after the request has been seen for
  // mem_lat cycles; mem_en=0 stalls it indefinitely.
  initial begin
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || imem_ack) begin
        imem_ack = 1'b0;
        mcnt = 0;
      end else if (mem_en && imem_req) begin
        mcnt++;
        if (mcnt >= mem_lat) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (imem_ack !== 1'b1 && n < 40) begin tick(); n++; end
    chk({tag, "_ack_seen"}, {31'h0, imem_ack}, 32'h1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 40) begin tick(); n++; end
    chk({tag, "_valid_seen"}, {31'h0, instr_valid}, 32'h1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin tick(); n++; end
    chk({tag, "_req_seen"}, {31'h0, imem_req}, 32'h1);
  endtask

  task automatic do_branch(input logic m, input logic [31:0] rv, input logic [31:0] iv,
                           input logic [7:0] bp);
    branch_valid = 1'b1;
    branch_mode = m;
    branch_reg = rv;
    branch_imm = iv;
    branch_pc = bp;
    tick();
    branch_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_pc", pc, 8'h00);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_link", link_addr, 0);
    chk("rst_flush", flush, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", fetch_error, 0);

    // Basic fetch: 2-cycle memory, decode always ready
    mem_lat = 2;
    instr_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ack("basic");
      chk("basic_addr", imem_addr, k);
      chk("basic_pre_valid", instr_valid, 0);
      tick();
      chk("basic_valid", instr_valid, 1);
      chk("basic_ipc", instr_pc, k);
      chk("basic_instr", instr, 32'h100 + k);
    end
    tick();
    instr_ready = 1'b0;

    // Backpressure on the word at pc 4
    wait_valid("bp");
    chk("bp_ipc", instr_pc, 8'h04);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", instr_valid, 1);
      chk("bp_hold_instr", instr, 32'h104);
      chk("bp_hold_ipc", instr_pc, 8'h04);
      chk("bp_no_req", imem_req, 0);
    end
    instr_ready = 1'b1;
    tick();
    chk("bp_release_valid", instr_valid, 0);
    tick();
    chk("bp_next_req", imem_req, 1);
    chk("bp_next_addr", imem_addr, 8'h05);
    instr_ready = 1'b0;
    wait_valid("w5");
    chk("w5_ipc", instr_pc, 8'h05);

    // Relative branch backwards, then with address wrap
    do_branch(1'b0, 32'h0, 32'hFFFF_FFFC, 8'h10);
    chk("rel_pc", pc, 8'h0C);
    chk("rel_link", link_addr, 8'h11);
    chk("rel_flush", flush, 1);
    chk("rel_valid", instr_valid, 0);
    tick();
    chk("rel_flush_end", flush, 0);
    wait_valid("rel");
    chk("rel_ipc", instr_pc, 8'h0C);
    chk("rel_instr", instr, 32'h10C);
    do_branch(1'b0, 32'h0, 32'h4, 8'hFE);
    chk("relwrap_pc", pc, 8'h02);
    chk("relwrap_link", link_addr, 8'hFF);
    wait_valid("relwrap");
    chk("relwrap_ipc", instr_pc, 8'h02);

    // Register jump while a fetch is outstanding
    mem_en = 1'b0;
    mem_lat = 1;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    wait_req("rj");
    chk("rj_old_addr", imem_addr, 8'h03);
    do_branch(1'b1, 32'h1234_5680, 32'h0, 8'h00);
    chk("rj_flush", flush, 1);
    chk("rj_pc", pc, 8'h80);
    chk("rj_link", link_addr, 8'h01);
    chk("rj_req_held", imem_req, 1);
    chk("rj_addr_held", imem_addr, 8'h03);
    mem_en = 1'b1;
    found = 0;
    spur = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      tick();
      if (instr_valid) spur++;
      if (imem_ack === 1'b1 && imem_addr === 8'h80) found = 1;
    end
    chk("rj_target_fetch", found, 1);
    chk("rj_discarded", spur, 0);
    tick();
    chk("rj_valid", instr_valid, 1);
    chk("rj_ipc", instr_pc, 8'h80);
    chk("rj_instr", instr, 32'h180);

    // Ack timeout with MAX_WAIT=4
    instr_ready = 1'b1;
    tick();
    mem_en = 1'b0;
    instr_ready = 1'b0;
    wait_req("to");
    tick(); tick(); tick();
    chk("to_not_yet", halted, 0);
    tick();
    chk("to_halted", halted, 1);
    chk("to_err", fetch_error, 1);
    chk("to_req", imem_req, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("to_start_ignored", halted, 1);
    chk("to_start_no_req", imem_req, 0);
    do_branch(1'b1, 32'h55, 32'h0, 8'h20);
    chk("halt_branch_flush", flush, 0);
    chk("halt_branch_pc", pc, 8'h81);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("to_rst_halted", halted, 0);
    chk("to_rst_err", fetch_error, 0);
    chk("to_rst_pc", pc, 8'h00);

    // PC wrap at 0xFF and halt requested during WAIT
    mem_en = 1'b1;
    mem_lat = 2;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid("wh");
    chk("wh_ipc0", instr_pc, 8'h00);
    do_branch(1'b1, 32'h0000_00FF, 32'h0, 8'h00);
    chk("wh_pc_ff", pc, 8'hFF);
    instr_ready = 1'b1;
    wait_ack("wh_ff");
    chk("wh_addr_ff", imem_addr, 8'hFF);
    tick();
    chk("wh_ipc_ff", instr_pc, 8'hFF);
    chk("wh_instr_ff", instr, 32'h1FF);
    chk("wh_pc_wrap", pc, 8'h00);
    wait_ack("wh_00");
    chk("wh_addr_00", imem_addr, 8'h00);
    tick();
    chk("wh_ipc_00", instr_pc, 8'h00);
    wait_req("wh_01");
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    wait_ack("wh_01");
    chk("wh_addr_01", imem_addr, 8'h01);
    tick();
    chk("wh_valid_01", instr_valid, 1);
    chk("wh_ipc_01", instr_pc, 8'h01);
    reqs = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (imem_req) reqs++;
    end
    chk("wh_no_req", reqs, 0);
    chk("wh_halted", halted, 1);
    chk("wh_pc", pc, 8'h02);

    // Randomized fetch / backpressure / branch run against the model
    instr_ready = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    exp_pc = 8'h00;
    for (int i = 0; i < 40; i++) begin
      mem_lat = $urandom_range(1, 3);
      wait_valid("rnd");
      chk("rnd_ipc", instr_pc, exp_pc);
      chk("rnd_instr", instr, mem_word(exp_pc));
      if ($urandom_range(0, 3) == 0) begin
        mode = 1'($urandom_range(0, 1));
        r = $urandom;
        imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
        bpc = 8'($urandom);
        do_branch(mode, r, imm, bpc);
        tgt = model_target(mode, r, imm, bpc);
        chk("rnd_br_pc", pc, tgt);
        chk("rnd_br_link", link_addr, bpc + 8'd1);
        chk("rnd_br_flush", flush, 1);
        chk("rnd_br_valid", instr_valid, 0);
        exp_pc = tgt;
      end else begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          chk("rnd_hold_valid", instr_valid, 1);
          chk("rnd_hold_ipc", instr_pc, exp_pc);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("rnd_accept", instr_valid, 0);
        exp_pc = exp_pc + 8'd1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
